// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter
//   Shares one variable-latency memory port between the OTTER fetch stage (IF)
//   and the MEM-stage load/store port (D). D has fixed priority, but IF cannot
//   starve: after MAX_WAIT consecutive D grants with IF pending, IF is forced.
//   Only one transaction is outstanding at a time. An IF response can be
//   discarded by if_kill (pipeline flush).
//
// Ports
//   CLK, RESET                      clock, async active-high reset
//   if_req/if_addr/if_kill          fetch request, address, flush
//   if_gnt/if_rvalid/if_rdata       fetch accept, response pulse, instruction
//   d_req/d_we/d_addr/d_wdata/
//   d_size/d_sign                   load/store request and payload
//   d_gnt/d_rvalid/d_rdata          data accept, response pulse, load data
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_size/mem_sign     backing-port request (latched copy)
//   mem_ack/mem_rdata               backing-port completion and read data
module otter_mem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_kill,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [1:0]        d_size,
    input  logic              d_sign,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        mem_size,
    output logic              mem_sign,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int WC_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D} state_t;

    state_t          state, state_n;
    logic [WC_W-1:0] wait_cnt, wait_cnt_n;
    logic            kill_q, kill_n;
    logic            if_force;

    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [1:0]        lat_size;
    logic              lat_sign;

    // IF has waited through MAX_WAIT D grants: it wins this arbitration.
    assign if_force = if_req && (wait_cnt == WC_W'(MAX_WAIT));

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        kill_n     = kill_q;
        if_gnt     = 1'b0;
        d_gnt      = 1'b0;
        mem_req    = 1'b0;
        case (state)
            IDLE: begin
                // Grants are combinational; suppress them while reset is held.
                if (!RESET) begin
                    if (d_req && !if_force) begin
                        d_gnt   = 1'b1;
                        state_n = BUSY_D;
                        if (if_req)
                            wait_cnt_n = (wait_cnt == WC_W'(MAX_WAIT)) ? wait_cnt
                                                                        : wait_cnt + 1'b1;
                        else
                            wait_cnt_n = '0;
                    end else if (if_req) begin
                        if_gnt     = 1'b1;
                        state_n    = BUSY_IF;
                        wait_cnt_n = '0;
                        // A flush in the grant cycle still lets the fetch go out,
                        // but its response must be dropped.
                        kill_n     = if_kill;
                    end else begin
                        wait_cnt_n = '0;
                    end
                end
            end
            BUSY_IF: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    state_n = IDLE;
                    kill_n  = 1'b0;
                end else if (if_kill) begin
                    kill_n = 1'b1;
                end
            end
            BUSY_D: begin
                mem_req = 1'b1;
                if (mem_ack) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            kill_q    <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_size  <= 2'b00;
            lat_sign  <= 1'b0;
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            kill_q   <= kill_n;

            if (d_gnt) begin
                lat_we    <= d_we;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
                lat_size  <= d_size;
                lat_sign  <= d_sign;
            end else if (if_gnt) begin
                lat_we    <= 1'b0;
                lat_addr  <= if_addr;
                lat_wdata <= '0;
                lat_size  <= 2'b10;
                lat_sign  <= 1'b1;
            end

            if_rvalid <= (state == BUSY_IF) && mem_ack && !kill_q && !if_kill;
            if ((state == BUSY_IF) && mem_ack && !kill_q && !if_kill)
                if_rdata <= mem_rdata;

            d_rvalid <= (state == BUSY_D) && mem_ack;
            if ((state == BUSY_D) && mem_ack)
                d_rdata <= lat_we ? '0 : mem_rdata;
        end
    end

    assign mem_we    = lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign mem_size  = lat_size;
    assign mem_sign  = lat_sign;

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Bench for otter_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_otter_mem_arbiter;

    localparam int MAX_WAIT = 4;

    logic        CLK, RESET;
    logic        if_req, if_kill, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_sign, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [1:0]  d_size;
    logic        mem_req, mem_we, mem_sign, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [1:0]  mem_size;

    int n_checks = 0;
    int n_fail   = 0;

    otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .CLK(CLK), .RESET(RESET),
        .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_size(d_size), .d_sign(d_sign),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_sign(mem_sign),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    // busy: 0 none outstanding, 1 fetch outstanding, 2 data outstanding.
    // wcnt: D grants handed out while IF was waiting.
    typedef struct {
        int          busy;
        int          wcnt;
        bit          kill;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        bit          sign;
        bit          if_rv;
        logic [31:0] if_rd;
        bit          d_rv;
        logic [31:0] d_rd;
        bit          last_ig;
        bit          last_dg;
    } mdl_t;

    mdl_t m  = '{default: 0};
    mdl_t mn = '{default: 0};

    always begin : model
        bit e_ig, e_dg;
        @(negedge CLK);
        if (RESET) begin
            chkb("rst_if_gnt", if_gnt, 1'b0);
            chkb("rst_d_gnt", d_gnt, 1'b0);
            chkb("rst_mem_req", mem_req, 1'b0);
            chkb("rst_if_rvalid", if_rvalid, 1'b0);
            chkb("rst_d_rvalid", d_rvalid, 1'b0);
            chk("rst_if_rdata", if_rdata, 32'h0);
            chk("rst_d_rdata", d_rdata, 32'h0);
            chk("rst_mem_addr", mem_addr, 32'h0);
            chk("rst_mem_wdata", mem_wdata, 32'h0);
            mn = '{default: 0};
        end else begin
            e_dg = (m.busy == 0) && d_req && !(if_req && m.wcnt >= MAX_WAIT);
            e_ig = (m.busy == 0) && !e_dg && if_req;
            chkb("m_if_gnt", if_gnt, e_ig);
            chkb("m_d_gnt", d_gnt, e_dg);
            chkb("m_mem_req", mem_req, m.busy != 0);
            chkb("m_if_rvalid", if_rvalid, m.if_rv);
            chkb("m_d_rvalid", d_rvalid, m.d_rv);
            if (m.if_rv) chk("m_if_rdata", if_rdata, m.if_rd);
            if (m.d_rv) chk("m_d_rdata", d_rdata, m.d_rd);
            if (m.busy != 0) begin
                chkb("m_mem_we", mem_we, m.we);
                chk("m_mem_addr", mem_addr, m.addr);
                chk("m_mem_wdata", mem_wdata, m.wdata);
                chk("m_mem_size", {30'b0, mem_size}, {30'b0, m.size});
                chkb("m_mem_sign", mem_sign, m.sign);
            end
            mn = m;
            mn.if_rv   = 1'b0;
            mn.d_rv    = 1'b0;
            mn.last_ig = e_ig;
            mn.last_dg = e_dg;
            if (e_dg) begin
                mn.busy  = 2;
                mn.we    = d_we;
                mn.addr  = d_addr;
                mn.wdata = d_wdata;
                mn.size  = d_size;
                mn.sign  = d_sign;
                mn.wcnt  = if_req ? ((m.wcnt + 1 > MAX_WAIT) ? MAX_WAIT : m.wcnt + 1) : 0;
            end else if (e_ig) begin
                mn.busy  = 1;
                mn.we    = 1'b0;
                mn.addr  = if_addr;
                mn.wdata = 32'h0;
                mn.size  = 2'b10;
                mn.sign  = 1'b1;
                mn.wcnt  = 0;
                mn.kill  = if_kill;
            end else if (m.busy == 0) begin
                mn.wcnt = 0;
            end else if (mem_ack) begin
                if (m.busy == 1) begin
                    mn.if_rv = !(m.kill || if_kill);
                    if (mn.if_rv) mn.if_rd = mem_rdata;
                    mn.kill = 1'b0;
                end else begin
                    mn.d_rv = 1'b1;
                    mn.d_rd = m.we ? 32'h0 : mem_rdata;
                end
                mn.busy = 0;
            end else if (m.busy == 1 && if_kill) begin
                mn.kill = 1'b1;
            end
        end
        @(posedge CLK);
        m = mn;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic neg();
        @(negedge CLK);
    endtask

    initial begin
        int dcnt0, dcnt1, nif;
        RESET = 1'b1;
        if_req = 0; if_addr = 0; if_kill = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_size = 0; d_sign = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) neg();
        chkb("reset_mem_req", mem_req, 1'b0);
        step(); RESET = 1'b0;

        // IF only: ack three cycles after grant
        step(); if_req = 1; if_addr = 32'h100;
        neg(); chkb("t1_if_gnt_c0", if_gnt, 1'b1);
        step(); if_req = 0;
        neg(); chkb("t1_mem_req_c1", mem_req, 1'b1);
        chk("t1_mem_addr", mem_addr, 32'h100);
        chk("t1_mem_size", {30'b0, mem_size}, 32'd2);
        chkb("t1_mem_sign", mem_sign, 1'b1);
        step(); neg(); chkb("t1_mem_req_c2", mem_req, 1'b1);
        step(); mem_ack = 1; mem_rdata = 32'h00500093;
        neg(); chkb("t1_mem_req_c3", mem_req, 1'b1);
        chkb("t1_no_rvalid_c3", if_rvalid, 1'b0);
        step(); mem_ack = 0; mem_rdata = 0;
        neg(); chkb("t1_if_rvalid_c4", if_rvalid, 1'b1);
        chk("t1_if_rdata_c4", if_rdata, 32'h00500093);
        chkb("t1_mem_req_c4", mem_req, 1'b0);
        step(); neg(); chkb("t1_if_rvalid_c5", if_rvalid, 1'b0);

        // IF and D together: D first, IF in the idle cycle carrying d_rvalid
        step(); if_req = 1; if_addr = 32'h104;
        d_req = 1; d_we = 0; d_addr = 32'h2000; d_size = 2'b10; d_sign = 0;
        neg(); chkb("t2_d_gnt", d_gnt, 1'b1); chkb("t2_if_gnt_c0", if_gnt, 1'b0);
        step(); d_req = 0; mem_ack = 1; mem_rdata = 32'h12345678;
        neg(); chk("t2_mem_addr_d", mem_addr, 32'h2000); chkb("t2_if_gnt_c1", if_gnt, 1'b0);
        step(); mem_ack = 0;
        neg(); chkb("t2_d_rvalid", d_rvalid, 1'b1); chk("t2_d_rdata", d_rdata, 32'h12345678);
        chkb("t2_if_gnt_c2", if_gnt, 1'b1);
        step(); if_req = 0; mem_ack = 1; mem_rdata = 32'hCAFEF00D;
        neg(); chk("t2_mem_addr_if", mem_addr, 32'h104);
        step(); mem_ack = 0;
        neg(); chkb("t2_if_rvalid", if_rvalid, 1'b1); chk("t2_if_rdata", if_rdata, 32'hCAFEF00D);

        // Continuous D with IF held: MAX_WAIT D grants then IF, twice
        step(); if_req = 1; if_addr = 32'h108; d_req = 1; d_addr = 32'h2004; mem_ack = 1;
        dcnt0 = 0; dcnt1 = 0; nif = 0;
        for (int c = 0; c < 60 && nif < 2; c++) begin
            neg();
            if (d_gnt) begin
                if (nif == 0) dcnt0++;
                else dcnt1++;
            end
            if (if_gnt) nif++;
            if (nif < 2) step();
        end
        chk("t3_if_grants", nif, 32'd2);
        chk("t3_d_grants_round1", dcnt0, 32'd4);
        chk("t3_d_grants_round2", dcnt1, 32'd4);
        step(); if_req = 0; d_req = 0;
        step(); mem_ack = 0;
        step();

        // Store
        step(); d_req = 1; d_we = 1; d_addr = 32'h11000000; d_wdata = 32'hDEADBEEF;
        d_size = 2'b10; d_sign = 0;
        neg(); chkb("t4_d_gnt", d_gnt, 1'b1);
        step(); d_req = 0; d_we = 0; mem_ack = 1; mem_rdata = 32'hFFFFFFFF;
        neg(); chkb("t4_mem_req", mem_req, 1'b1); chkb("t4_mem_we", mem_we, 1'b1);
        chk("t4_mem_addr", mem_addr, 32'h11000000); chk("t4_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("t4_mem_size", {30'b0, mem_size}, 32'd2);
        step(); mem_ack = 0;
        neg(); chkb("t4_d_rvalid", d_rvalid, 1'b1); chk("t4_d_rdata", d_rdata, 32'h0);
        step(); neg(); chkb("t4_d_rvalid_off", d_rvalid, 1'b0);

        // Kill an in-flight fetch, then fetch normally
        step(); if_req = 1; if_addr = 32'h200;
        neg(); chkb("t5_if_gnt", if_gnt, 1'b1);
        step(); if_req = 0;
        step(); if_kill = 1;
        step(); if_kill = 0; mem_ack = 1; mem_rdata = 32'h11111111;
        step(); mem_ack = 0;
        neg(); chkb("t5_killed_rvalid", if_rvalid, 1'b0);
        step(); if_req = 1; if_addr = 32'h204;
        neg(); chkb("t5_refetch_gnt", if_gnt, 1'b1);
        step(); if_req = 0; mem_ack = 1; mem_rdata = 32'h22222222;
        step(); mem_ack = 0;
        neg(); chkb("t5_refetch_rvalid", if_rvalid, 1'b1);
        chk("t5_refetch_rdata", if_rdata, 32'h22222222);

        // Reset in the middle of a data transaction
        step(); d_req = 1; d_we = 0; d_addr = 32'h3000;
        neg(); chkb("t6_d_gnt", d_gnt, 1'b1);
        step(); d_req = 0;
        neg(); chkb("t6_mem_req_busy", mem_req, 1'b1);
        step(); RESET = 1; mem_ack = 1;
        #1; chkb("t6_mem_req_in_reset", mem_req, 1'b0);
        chkb("t6_d_rvalid_in_reset", d_rvalid, 1'b0);
        step(); RESET = 0;
        neg(); chkb("t6_d_rvalid_after", d_rvalid, 1'b0); chkb("t6_mem_req_after", mem_req, 1'b0);
        step(); mem_ack = 0; if_req = 1; if_addr = 32'h300;
        neg(); chkb("t6_idle_if_gnt", if_gnt, 1'b1);
        step(); if_req = 0; mem_ack = 1;
        step(); mem_ack = 0;

        // Randomized traffic; the model checks every cycle
        for (int c = 0; c < 3000; c++) begin
            step();
            if (m.last_ig) begin
                if_req = ($urandom_range(0, 1) == 1);
                if_addr = $urandom;
            end else if (if_req) begin
                if ($urandom_range(0, 19) == 0) if_req = 0;
            end else if ($urandom_range(0, 2) == 0) begin
                if_req = 1;
                if_addr = $urandom;
            end
            if (m.last_dg || !d_req) begin
                d_req = m.last_dg ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 2) == 0);
                d_we = $urandom_range(0, 1) == 1;
                d_addr = $urandom;
                d_wdata = $urandom;
                d_size = 2'($urandom_range(0, 2));
                d_sign = $urandom_range(0, 1) == 1;
            end else if ($urandom_range(0, 19) == 0) begin
                d_req = 0;
            end
            if_kill = ($urandom_range(0, 9) == 0);
            mem_ack = ($urandom_range(0, 4) < 2);
            mem_rdata = $urandom;
            RESET = ($urandom_range(0, 299) == 0);
        end
        step();
        RESET = 0; if_req = 0; d_req = 0; if_kill = 0; mem_ack = 1;
        repeat (4) step();
        mem_ack = 0;
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
